axi_lite_reg_slave: RTL and testbench

- AXI4-Lite slave front end that turns bus transactions into a simple strobe-based register interface for user logic.
- Handles one transaction at a time, either a write or a read.
- Presents the register address, data and request to user logic, waits for the user's acknowledge strobe, then returns the AXI response.
- Sits between the AXI-Lite interconnect and a block's register file.

---
 rtl/axi_lite_reg_pkg.sv | 22 ++
 rtl/axi_lite_reg_slave.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axi_lite_reg_pkg;

    // Transaction sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_USER,
        ST_WR_RESP,
        ST_RD_USER,
        ST_RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bus response code for a user-flagged bad address
    function automatic logic [1:0] resp_for(input logic invalid_addr);
        return invalid_addr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave that hands one transaction at a time to a strobe-based
// register interface and returns the user's completion as the bus response.
module axi_lite_reg_slave
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_awvalid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    output logic                    o_awready,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [STROBE_WIDTH-1:0] i_wstrb,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [1:0]              o_rresp,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [ADDR_WIDTH-1:0]   o_reg_address,
    input  logic                    i_reg_invalid_addr,
    output logic                    o_reg_in_rdy,
    input  logic                    i_reg_in_ack_stb,
    output logic [DATA_WIDTH-1:0]   o_reg_in_data,
    output logic                    o_reg_out_req,
    input  logic                    i_reg_out_rdy_stb,
    input  logic [DATA_WIDTH-1:0]   i_reg_out_data
);

    state_e state_q;
    state_e state_d;
    logic   have_aw_q;
    logic   have_w_q;

    // Byte strobes are not honoured; every write is a full word.
    logic wstrb_unused;
    assign wstrb_unused = ^i_wstrb;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and channel handshake decode
    always_comb begin
        state_d       = state_q;
        o_awready     = 1'b0;
        o_wready      = 1'b0;
        o_arready     = 1'b0;
        o_bvalid      = 1'b0;
        o_rvalid      = 1'b0;
        o_reg_in_rdy  = 1'b0;
        o_reg_out_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_awready = 1'b1;
                o_wready  = 1'b1;
                // A pending write in the same cycle wins over a read.
                o_arready = !i_awvalid && !i_wvalid;
                if (i_awvalid && i_wvalid) begin
                    state_d = ST_WR_USER;
                end else if (i_awvalid || i_wvalid) begin
                    state_d = ST_WR_WAIT;
                end else if (i_arvalid) begin
                    state_d = ST_RD_USER;
                end
            end
            ST_WR_WAIT: begin
                o_awready = !have_aw_q;
                o_wready  = !have_w_q;
                if ((!have_aw_q && i_awvalid) || (!have_w_q && i_wvalid)) begin
                    state_d = ST_WR_USER;
                end
            end
            ST_WR_USER: begin
                o_reg_in_rdy = 1'b1;
                if (i_reg_in_ack_stb) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_USER: begin
                o_reg_out_req = 1'b1;
                if (i_reg_out_rdy_stb) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Nothing is offered to the bus or the user while reset is held.
        if (rst) begin
            state_d       = ST_IDLE;
            o_awready     = 1'b0;
            o_wready      = 1'b0;
            o_arready     = 1'b0;
            o_bvalid      = 1'b0;
            o_rvalid      = 1'b0;
            o_reg_in_rdy  = 1'b0;
            o_reg_out_req = 1'b0;
        end
    end

    // Address, data and response capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            have_aw_q     <= 1'b0;
            have_w_q      <= 1'b0;
            o_reg_address <= '0;
            o_reg_in_data <= '0;
            o_rdata       <= '0;
            o_bresp       <= RESP_OKAY;
            o_rresp       <= RESP_OKAY;
        end else begin
            if (o_awready && i_awvalid) begin
                o_reg_address <= i_awaddr;
                have_aw_q     <= 1'b1;
            end
            if (o_wready && i_wvalid) begin
                o_reg_in_data <= i_wdata;
                have_w_q      <= 1'b1;
            end
            if (o_arready && i_arvalid) begin
                o_reg_address <= i_araddr;
            end
            if (state_q == ST_WR_USER) begin
                have_aw_q <= 1'b0;
                have_w_q  <= 1'b0;
                if (i_reg_in_ack_stb) begin
                    o_bresp <= resp_for(i_reg_invalid_addr);
                end
            end
            if (state_q == ST_RD_USER && i_reg_out_rdy_stb) begin
                o_rdata <= i_reg_out_data;
                o_rresp <= resp_for(i_reg_invalid_addr);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a transaction-level reference model.
module tb_axi_lite_reg_slave;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    localparam int SEL_IN_RDY  = 0;
    localparam int SEL_BVALID  = 1;
    localparam int SEL_OUT_REQ = 2;
    localparam int SEL_RVALID  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_awvalid = 1'b0;
    logic [AW-1:0] i_awaddr = '0;
    logic          o_awready;
    logic          i_wvalid = 1'b0;
    logic          o_wready;
    logic [SW-1:0] i_wstrb = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          o_bvalid;
    logic          i_bready = 1'b0;
    logic [1:0]    o_bresp;
    logic          i_arvalid = 1'b0;
    logic          o_arready;
    logic [AW-1:0] i_araddr = '0;
    logic          o_rvalid;
    logic          i_rready = 1'b0;
    logic [1:0]    o_rresp;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_reg_address;
    logic          i_reg_invalid_addr = 1'b0;
    logic          o_reg_in_rdy;
    logic          i_reg_in_ack_stb = 1'b0;
    logic [DW-1:0] o_reg_in_data;
    logic          o_reg_out_req;
    logic          i_reg_out_rdy_stb = 1'b0;
    logic [DW-1:0] i_reg_out_data = '0;

    axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_reg_address(o_reg_address), .i_reg_invalid_addr(i_reg_invalid_addr),
        .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
        .o_reg_in_data(o_reg_in_data), .o_reg_out_req(o_reg_out_req),
        .i_reg_out_rdy_stb(i_reg_out_rdy_stb), .i_reg_out_data(i_reg_out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the current transaction has collected so far
    bit            m_on = 1'b0;
    bit            m_got_aw = 1'b0;
    bit            m_got_w = 1'b0;
    bit            m_acked = 1'b0;
    bit            m_rd_busy = 1'b0;
    bit            m_rd_done = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_bresp = 2'b00;
    logic [1:0]    m_rresp = 2'b00;

    function automatic logic e_idle();
        return !m_got_aw && !m_got_w && !m_rd_busy;
    endfunction
    function automatic logic e_awready();
        return !rst && !m_rd_busy && !m_got_aw;
    endfunction
    function automatic logic e_wready();
        return !rst && !m_rd_busy && !m_got_w;
    endfunction
    function automatic logic e_arready();
        return !rst && e_idle() && !i_awvalid && !i_wvalid;
    endfunction
    function automatic logic e_in_rdy();
        return !rst && m_got_aw && m_got_w && !m_acked;
    endfunction
    function automatic logic e_bvalid();
        return !rst && m_acked;
    endfunction
    function automatic logic e_out_req();
        return !rst && m_rd_busy && !m_rd_done;
    endfunction
    function automatic logic e_rvalid();
        return !rst && m_rd_done;
    endfunction

    // Advance the model on each active edge from the inputs it sees
    always @(posedge clk) begin
        bit aw_hs, w_hs, ar_hs, wack, rack, bdone, rdone;
        if (rst) begin
            m_on = 1'b1;
            m_got_aw = 1'b0; m_got_w = 1'b0; m_acked = 1'b0;
            m_rd_busy = 1'b0; m_rd_done = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_bresp = 2'b00; m_rresp = 2'b00;
        end else if (m_on) begin
            aw_hs = i_awvalid && e_awready();
            w_hs  = i_wvalid && e_wready();
            ar_hs = i_arvalid && e_arready();
            wack  = e_in_rdy() && i_reg_in_ack_stb;
            rack  = e_out_req() && i_reg_out_rdy_stb;
            bdone = m_acked && i_bready;
            rdone = m_rd_done && i_rready;
            if (aw_hs) begin m_got_aw = 1'b1; m_addr = i_awaddr; end
            if (w_hs) begin m_got_w = 1'b1; m_wdata = i_wdata; end
            if (ar_hs) begin m_rd_busy = 1'b1; m_addr = i_araddr; end
            if (wack) begin
                m_acked = 1'b1;
                m_bresp = i_reg_invalid_addr ? 2'b10 : 2'b00;
            end
            if (bdone) begin m_got_aw = 1'b0; m_got_w = 1'b0; m_acked = 1'b0; end
            if (rack) begin
                m_rd_done = 1'b1;
                m_rdata = i_reg_out_data;
                m_rresp = i_reg_invalid_addr ? 2'b10 : 2'b00;
            end
            if (rdone) begin m_rd_busy = 1'b0; m_rd_done = 1'b0; end
        end
    end

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (m_on) begin
            chk("awready", 32'(o_awready), 32'(e_awready()));
            chk("wready", 32'(o_wready), 32'(e_wready()));
            chk("arready", 32'(o_arready), 32'(e_arready()));
            chk("bvalid", 32'(o_bvalid), 32'(e_bvalid()));
            chk("rvalid", 32'(o_rvalid), 32'(e_rvalid()));
            chk("in_rdy", 32'(o_reg_in_rdy), 32'(e_in_rdy()));
            chk("out_req", 32'(o_reg_out_req), 32'(e_out_req()));
            chk("reg_address", 32'(o_reg_address), 32'(m_addr));
            chk("reg_in_data", o_reg_in_data, m_wdata);
            chk("rdata", o_rdata, m_rdata);
            chk("bresp", 32'(o_bresp), 32'(m_bresp));
            chk("rresp", 32'(o_rresp), 32'(m_rresp));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_IN_RDY:  return o_reg_in_rdy;
            SEL_BVALID:  return o_bvalid;
            SEL_OUT_REQ: return o_reg_out_req;
            SEL_RVALID:  return o_rvalid;
            default:     return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int sel, input string name);
        for (int i = 0; i < 50; i++) begin
            if (sig(sel)) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, got 0 expected 1 within 50 cycles", name);
    endtask

    task automatic send_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        i_awvalid = 1'b1; i_awaddr = addr;
        i_wvalid = 1'b1; i_wdata = data; i_wstrb = 4'h3;
        step();
        i_awvalid = 1'b0; i_wvalid = 1'b0;
    endtask

    task automatic finish_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic invalid, input int ack_delay, input logic [1:0] bresp);
        wait_until(SEL_IN_RDY, "wait_in_rdy");
        chk("wr_addr", 32'(o_reg_address), 32'(addr));
        chk("wr_data", o_reg_in_data, data);
        repeat (ack_delay) step();
        i_reg_in_ack_stb = 1'b1; i_reg_invalid_addr = invalid;
        step();
        i_reg_in_ack_stb = 1'b0; i_reg_invalid_addr = 1'b0;
        chk("in_rdy_after_ack", 32'(o_reg_in_rdy), 32'd0);
        wait_until(SEL_BVALID, "wait_bvalid");
        chk("wr_bresp", 32'(o_bresp), 32'(bresp));
        i_bready = 1'b1;
        step();
        i_bready = 1'b0;
        chk("bvalid_after_bready", 32'(o_bvalid), 32'd0);
    endtask

    task automatic start_read(input logic [AW-1:0] addr);
        i_arvalid = 1'b1; i_araddr = addr;
        step();
        i_arvalid = 1'b0;
    endtask

    task automatic finish_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic invalid, input logic [1:0] rresp, input int hold);
        wait_until(SEL_OUT_REQ, "wait_out_req");
        chk("rd_addr", 32'(o_reg_address), 32'(addr));
        i_reg_out_data = data; i_reg_out_rdy_stb = 1'b1; i_reg_invalid_addr = invalid;
        step();
        i_reg_out_rdy_stb = 1'b0; i_reg_invalid_addr = 1'b0; i_reg_out_data = ~data;
        wait_until(SEL_RVALID, "wait_rvalid");
        for (int i = 0; i <= hold; i++) begin
            chk("rd_data", o_rdata, data);
            chk("rd_resp", 32'(o_rresp), 32'(rresp));
            chk("rd_valid_held", 32'(o_rvalid), 32'd1);
            if (i < hold) step();
        end
        i_rready = 1'b1;
        step();
        i_rready = 1'b0;
        chk("rvalid_after_rready", 32'(o_rvalid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst_awready", 32'(o_awready), 32'd0);
        chk("rst_arready", 32'(o_arready), 32'd0);
        chk("rst_address", 32'(o_reg_address), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_bresp", 32'(o_bresp), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_awready", 32'(o_awready), 32'd1);
        chk("idle_arready", 32'(o_arready), 32'd1);

        // Stray user strobes while idle have no effect
        i_reg_in_ack_stb = 1'b1; i_reg_out_rdy_stb = 1'b1;
        step();
        i_reg_in_ack_stb = 1'b0; i_reg_out_rdy_stb = 1'b0;
        chk("stray_bvalid", 32'(o_bvalid), 32'd0);
        chk("stray_rvalid", 32'(o_rvalid), 32'd0);

        // Combined write, then read back with a stalled rready
        send_write(5'h00, 32'hDEADBEEF);
        finish_write(5'h00, 32'hDEADBEEF, 1'b0, 1, 2'b00);
        start_read(5'h00);
        finish_read(5'h00, 32'hDEADBEEF, 1'b0, 2'b00, 3);

        // Data before address
        i_wvalid = 1'b1; i_wdata = 32'h12345678;
        step();
        i_wvalid = 1'b0;
        chk("split_in_rdy", 32'(o_reg_in_rdy), 32'd0);
        chk("split_awready", 32'(o_awready), 32'd1);
        chk("split_wready", 32'(o_wready), 32'd0);
        chk("split_arready", 32'(o_arready), 32'd0);
        step();
        chk("split_in_rdy2", 32'(o_reg_in_rdy), 32'd0);
        i_awvalid = 1'b1; i_awaddr = 5'h01;
        step();
        i_awvalid = 1'b0;
        finish_write(5'h01, 32'h12345678, 1'b0, 0, 2'b00);

        // Bad address reported by the user
        send_write(5'h1F, 32'h55AA00FF);
        finish_write(5'h1F, 32'h55AA00FF, 1'b1, 2, 2'b10);
        start_read(5'h1F);
        finish_read(5'h1F, 32'hCAFEF00D, 1'b1, 2'b10, 1);

        // Simultaneous write and read requests: write goes first
        i_awvalid = 1'b1; i_awaddr = 5'h02;
        i_wvalid = 1'b1; i_wdata = 32'hA5A55A5A;
        i_arvalid = 1'b1; i_araddr = 5'h03;
        #1;
        chk("simul_arready", 32'(o_arready), 32'd0);
        step();
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        chk("simul_arready_wr", 32'(o_arready), 32'd0);
        finish_write(5'h02, 32'hA5A55A5A, 1'b0, 1, 2'b00);
        chk("simul_arready_after", 32'(o_arready), 32'd1);
        step();
        i_arvalid = 1'b0;
        finish_read(5'h03, 32'h0BADF00D, 1'b0, 2'b00, 0);

        // Reset while the user is being asked for read data
        start_read(5'h04);
        wait_until(SEL_OUT_REQ, "wait_out_req_rst");
        rst = 1'b1;
        step();
        chk("mid_rst_out_req", 32'(o_reg_out_req), 32'd0);
        chk("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("mid_rst_awready", 32'(o_awready), 32'd0);
        chk("mid_rst_address", 32'(o_reg_address), 32'd0);
        chk("mid_rst_in_data", o_reg_in_data, 32'd0);
        chk("mid_rst_rdata", o_rdata, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_out_req", 32'(o_reg_out_req), 32'd0);
        chk("post_rst_awready", 32'(o_awready), 32'd1);
        send_write(5'h06, 32'h600DCAFE);
        finish_write(5'h06, 32'h600DCAFE, 1'b0, 0, 2'b00);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
